// File: rtl/wam_lvl_ctl.sv
// Whac-A-Mole difficulty-level controller: debounced easier/harder buttons, auto-harder on
// the score carry, auto-easier after a run of misses, and a lockout window against thrash.

module wam_lvl_db #(
    parameter int DB_CNT = 5
) (
    input  logic clk_19,
    input  logic clr,
    input  logic din,
    output logic pulse
);
    typedef enum logic {IDLE, CNT} db_state_t;

    localparam logic [3:0] CNT_LAST = 4'(DB_CNT - 1);

    db_state_t  state;
    db_state_t  state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       prev;
    logic       rise;
    logic       pulse_nxt;

    assign rise = din & ~prev;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_19) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            prev  <= din;  // a button held through clr must not look like a fresh press
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prev  <= din;
            pulse <= pulse_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = CNT;
                    cnt_nxt   = 4'd1;
                end
            end
            CNT: begin
                if (rise || !din) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    pulse_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
        endcase
    end
endmodule

module wam_lvl_ctl #(
    parameter int NLVL     = 4,
    parameter int LVL_MIN  = 1,
    parameter int LVL_RST  = 1,
    parameter int DB_CNT   = 5,
    parameter int MISS_LIM = 3,
    parameter int HOLD     = 8
) (
    input  logic                    clk_19,
    input  logic                    clr,
    input  logic                    lft,
    input  logic                    rgt,
    input  logic                    cout0,
    input  logic                    miss,
    input  logic                    hit,
    input  logic                    auto_en,
    output logic [$clog2(NLVL)-1:0] lvl,
    output logic                    lvl_chg,
    output logic                    at_min,
    output logic                    at_max
);
    localparam int LW = $clog2(NLVL);
    localparam int MW = $clog2(MISS_LIM + 1);
    localparam int HW = $clog2(HOLD + 1);

    localparam logic [LW-1:0] L_MIN = LW'(LVL_MIN);
    localparam logic [LW-1:0] L_MAX = LW'(NLVL - 1);
    localparam logic [LW-1:0] L_RST = LW'(LVL_RST);
    localparam logic [MW-1:0] M_LIM = MW'(MISS_LIM);
    localparam logic [HW-1:0] H_LD  = HW'(HOLD);

    typedef enum logic [1:0] {REQ_NONE, REQ_EASY, REQ_HARD} req_t;

    logic          lft_p;
    logic          rgt_p;
    logic          cout_p;
    logic          lock_free;
    logic          h_auto;
    logic          e_auto;
    req_t          req;
    logic [LW-1:0] lvl_nxt;
    logic          chg;
    logic [MW-1:0] miss_cnt;
    logic [MW-1:0] miss_nxt;
    logic [HW-1:0] lock;
    logic [HW-1:0] lock_nxt;

    wam_lvl_db #(.DB_CNT(DB_CNT)) u_db_lft  (.clk_19(clk_19), .clr(clr), .din(lft),   .pulse(lft_p));
    wam_lvl_db #(.DB_CNT(DB_CNT)) u_db_rgt  (.clk_19(clk_19), .clr(clr), .din(rgt),   .pulse(rgt_p));
    wam_lvl_db #(.DB_CNT(DB_CNT)) u_db_cout (.clk_19(clk_19), .clr(clr), .din(cout0), .pulse(cout_p));

    assign lock_free = (lock == '0);
    assign h_auto    = cout_p & auto_en & lock_free;
    assign e_auto    = (miss_cnt == M_LIM) & auto_en & lock_free;

    // Only the highest-priority request survives; a simultaneous easier+harder cancels all.
    always_comb begin
        req = REQ_NONE;
        if (lft_p && rgt_p) begin
            req = REQ_NONE;
        end else if (lft_p) begin
            req = REQ_EASY;
        end else if (rgt_p) begin
            req = REQ_HARD;
        end else if (h_auto) begin
            req = REQ_HARD;
        end else if (e_auto) begin
            req = REQ_EASY;
        end
    end

    always_comb begin
        lvl_nxt = lvl;
        chg     = 1'b0;
        case (req)
            REQ_EASY: begin
                if (lvl > L_MIN) begin
                    lvl_nxt = lvl - LW'(1);
                    chg     = 1'b1;
                end
            end
            REQ_HARD: begin
                if (lvl < L_MAX) begin
                    lvl_nxt = lvl + LW'(1);
                    chg     = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // A blocked miss count parks at the limit and fires once auto changes are allowed again.
    always_comb begin
        miss_nxt = miss_cnt;
        if (chg || hit) begin
            miss_nxt = '0;
        end else if (miss && (miss_cnt != M_LIM)) begin
            miss_nxt = miss_cnt + MW'(1);
        end
    end

    always_comb begin
        lock_nxt = lock;
        if (chg) begin
            lock_nxt = H_LD;
        end else if (!lock_free) begin
            lock_nxt = lock - HW'(1);
        end
    end

    always_ff @(posedge clk_19) begin
        if (clr) begin
            lvl      <= L_RST;
            lvl_chg  <= 1'b0;
            miss_cnt <= '0;
            lock     <= '0;
        end else begin
            lvl      <= lvl_nxt;
            lvl_chg  <= chg;
            miss_cnt <= miss_nxt;
            lock     <= lock_nxt;
        end
    end

    assign at_min = (lvl == L_MIN);
    assign at_max = (lvl == L_MAX);
endmodule

// File: tb/tb_wam_lvl_ctl.sv
// Bench for wam_lvl_ctl: a scripted vector table, hand-written corner sequences and a random
// phase, all compared every cycle against a run-length/priority reference model.

module tb_wam_lvl_ctl;
    localparam int NLVL     = 4;
    localparam int LVL_MIN  = 1;
    localparam int LVL_RST  = 1;
    localparam int DB_CNT   = 5;
    localparam int MISS_LIM = 3;
    localparam int HOLD     = 8;
    localparam int LW       = $clog2(NLVL);

    logic          clk_19 = 1'b0;
    logic          clr;
    logic          lft;
    logic          rgt;
    logic          cout0;
    logic          miss;
    logic          hit;
    logic          auto_en;
    logic [LW-1:0] lvl;
    logic          lvl_chg;
    logic          at_min;
    logic          at_max;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: level/lockout/miss state plus, per input channel (lft, rgt, cout0),
    // the length of the current run of 1-samples and whether clr landed inside that run.
    int m_lvl  = 0;
    int m_lock = 0;
    int m_miss = 0;
    bit m_chg  = 1'b0;
    bit m_p    [3];
    int m_run  [3];
    bit m_dead [3];

    typedef struct {
        logic clr, lft, rgt, cout0, miss, hit, auto_en;
        int   lvl;
        logic chg;
    } vec_t;

    wam_lvl_ctl #(
        .NLVL(NLVL), .LVL_MIN(LVL_MIN), .LVL_RST(LVL_RST),
        .DB_CNT(DB_CNT), .MISS_LIM(MISS_LIM), .HOLD(HOLD)
    ) dut (
        .clk_19(clk_19), .clr(clr), .lft(lft), .rgt(rgt), .cout0(cout0),
        .miss(miss), .hit(hit), .auto_en(auto_en),
        .lvl(lvl), .lvl_chg(lvl_chg), .at_min(at_min), .at_max(at_max)
    );

    always #5 clk_19 = ~clk_19;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic r, input logic co,
                                input logic ms, input logic ht, input logic ae,
                                input int lv, input logic ch);
        vec_t v;
        v.clr = c; v.lft = l; v.rgt = r; v.cout0 = co;
        v.miss = ms; v.hit = ht; v.auto_en = ae;
        v.lvl = lv; v.chg = ch;
        return v;
    endfunction

    task automatic model_edge();
        bit in_v [3];
        int dir;
        int tgt;
        bit chg_now;
        in_v[0] = lft;
        in_v[1] = rgt;
        in_v[2] = cout0;
        if (clr) begin
            m_lvl  = LVL_RST;
            m_chg  = 1'b0;
            m_lock = 0;
            m_miss = 0;
        end else begin
            dir = 0;
            if (m_p[0] && m_p[1])                                     dir = 0;
            else if (m_p[0])                                          dir = -1;
            else if (m_p[1])                                          dir = 1;
            else if (auto_en && m_lock == 0 && m_p[2])                dir = 1;
            else if (auto_en && m_lock == 0 && m_miss == MISS_LIM)    dir = -1;
            tgt     = m_lvl + dir;
            chg_now = (dir != 0) && (tgt >= LVL_MIN) && (tgt <= NLVL - 1);
            if (chg_now) m_lvl = tgt;
            m_chg = chg_now;
            if (chg_now || hit)              m_miss = 0;
            else if (miss && m_miss < MISS_LIM) m_miss++;
            m_lock = chg_now ? HOLD : ((m_lock > 0) ? m_lock - 1 : 0);
        end
        // A press qualifies when the input has been 1 for exactly DB_CNT samples since a 0.
        for (int i = 0; i < 3; i++) begin
            if (!in_v[i]) begin
                m_run[i]  = 0;
                m_dead[i] = 1'b0;
            end else begin
                m_run[i]++;
                if (clr) m_dead[i] = 1'b1;
            end
            m_p[i] = !clr && in_v[i] && !m_dead[i] && (m_run[i] == DB_CNT);
        end
    endtask

    task automatic tick();
        int exp_w;
        @(posedge clk_19);
        model_edge();
        @(negedge clk_19);
        exp_w = (m_lvl << 3) | (int'(m_chg) << 2) | (int'(m_lvl == LVL_MIN) << 1)
              | int'(m_lvl == NLVL - 1);
        check("model_cycle", int'({lvl, lvl_chg, at_min, at_max}), exp_w);
    endtask

    task automatic run(input int len, inout int nchg);
        repeat (len) begin
            tick();
            if (lvl_chg === 1'b1) nchg++;
        end
    endtask

    task automatic hold_in(input logic [2:0] sel, input int len, inout int nchg);
        {lft, rgt, cout0} = sel;
        run(len, nchg);
        {lft, rgt, cout0} = 3'b000;
    endtask

    task automatic ev(input logic m, input logic h, inout int nchg);
        miss = m;
        hit  = h;
        run(1, nchg);
        miss = 1'b0;
        hit  = 1'b0;
    endtask

    initial begin
        vec_t       tbl[$];
        int         nchg;
        logic [2:0] b;
        {clr, lft, rgt, cout0, miss, hit, auto_en} = 7'b0;
        b = 3'b000;

        // Reset, then rgt held for 10 cycles: level steps 1 -> 2 on the 6th cycle after the rise.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0));
        for (int i = 1; i <= 10; i++)
            tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                             (i >= 6) ? 2 : 1, (i == 6)));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0));

        foreach (tbl[i]) begin
            {clr, lft, rgt, cout0, miss, hit, auto_en} =
                {tbl[i].clr, tbl[i].lft, tbl[i].rgt, tbl[i].cout0,
                 tbl[i].miss, tbl[i].hit, tbl[i].auto_en};
            tick();
            check($sformatf("tbl%0d_lvl", i), int'(lvl), tbl[i].lvl);
            check($sformatf("tbl%0d_chg", i), int'(lvl_chg), int'(tbl[i].chg));
            check($sformatf("tbl%0d_min", i), int'(at_min), int'(tbl[i].lvl == LVL_MIN));
            check($sformatf("tbl%0d_max", i), int'(at_max), int'(tbl[i].lvl == NLVL - 1));
        end
        clr = 1'b0;

        // Two more harder presses: 2 -> 3, then saturated with no pulse.
        nchg = 0; hold_in(3'b010, 10, nchg); run(2, nchg);
        check("press2_chg", nchg, 1);
        check("press2_lvl", int'(lvl), 3);
        nchg = 0; hold_in(3'b010, 10, nchg); run(2, nchg);
        check("press3_chg", nchg, 0);
        check("press3_lvl", int'(lvl), 3);
        check("press3_max", int'(at_max), 1);

        // Bounce 1,0,1 then held: aborts, requalifies, one step only.
        clr = 1'b1; nchg = 0; run(1, nchg); clr = 1'b0;
        check("clr_lvl", int'(lvl), LVL_RST);
        nchg = 0;
        hold_in(3'b010, 1, nchg); run(1, nchg); hold_in(3'b010, 8, nchg); run(2, nchg);
        check("bounce_chg", nchg, 1);
        check("bounce_lvl", int'(lvl), 2);
        nchg = 0; hold_in(3'b010, 2, nchg); run(8, nchg);
        check("glitch_chg", nchg, 0);
        check("glitch_lvl", int'(lvl), 2);

        // Auto easier after three misses; an interleaved hit restarts the count.
        auto_en = 1'b1;
        nchg = 0; run(10, nchg);
        ev(1'b1, 1'b0, nchg); run(1, nchg); ev(1'b1, 1'b0, nchg); run(1, nchg);
        ev(1'b1, 1'b0, nchg); run(3, nchg);
        check("miss3_chg", nchg, 1);
        check("miss3_lvl", int'(lvl), 1);
        nchg = 0; hold_in(3'b010, 6, nchg); run(10, nchg);
        check("reup_lvl", int'(lvl), 2);
        nchg = 0;
        ev(1'b1, 1'b0, nchg); ev(1'b0, 1'b1, nchg); ev(1'b1, 1'b0, nchg); ev(1'b1, 1'b0, nchg);
        run(4, nchg);
        check("mhmm_chg", nchg, 0);
        check("mhmm_lvl", int'(lvl), 2);
        nchg = 0; ev(1'b1, 1'b0, nchg); run(3, nchg);
        check("miss_tail_chg", nchg, 1);
        check("miss_tail_lvl", int'(lvl), 1);

        // Score carry: first accepted, second inside the lockout ignored, third accepted.
        nchg = 0; run(10, nchg); hold_in(3'b001, 6, nchg); run(1, nchg);
        check("cout1_chg", nchg, 1);
        check("cout1_lvl", int'(lvl), 2);
        nchg = 0; hold_in(3'b001, 6, nchg);
        check("cout_locked_chg", nchg, 0);
        check("cout_locked_lvl", int'(lvl), 2);
        nchg = 0; run(10, nchg); hold_in(3'b001, 6, nchg); run(1, nchg);
        check("cout3_chg", nchg, 1);
        check("cout3_lvl", int'(lvl), 3);

        // lft+rgt together cancel; lft beats a simultaneous carry; clr mid-filter kills a press.
        nchg = 0; run(10, nchg); hold_in(3'b110, 6, nchg); run(2, nchg);
        check("both_chg", nchg, 0);
        check("both_lvl", int'(lvl), 3);
        nchg = 0; hold_in(3'b101, 6, nchg); run(2, nchg);
        check("lft_cout_chg", nchg, 1);
        check("lft_cout_lvl", int'(lvl), 2);
        nchg = 0; run(10, nchg);
        nchg = 0;
        rgt = 1'b1; run(2, nchg);
        clr = 1'b1; run(1, nchg); clr = 1'b0;
        run(8, nchg); rgt = 1'b0; run(2, nchg);
        check("clr_cnt_chg", nchg, 0);
        check("clr_cnt_lvl", int'(lvl), LVL_RST);
        check("clr_cnt_min", int'(at_min), 1);
        check("clr_cnt_max", int'(at_max), 0);

        // Random phase against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(5) == 0) b[k] = ~b[k];
            {lft, rgt, cout0} = b;
            miss = ($urandom_range(3) == 0);
            hit  = ($urandom_range(9) == 0);
            clr  = ($urandom_range(299) == 0);
            if ($urandom_range(39) == 0) auto_en = ~auto_en;
            tick();
        end
        {clr, lft, rgt, cout0, miss, hit} = 6'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
